// File: rtl/rmii_rx_checker.sv
// RMII receive frame checker: dibit-to-byte assembly, preamble/SFD strip,
// CRC-32 residue, length/alignment checks and saturating frame counters.
module rmii_rx_checker #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [1:0]  rxd,
   input  logic        rx_dv,
   input  logic        rx_er,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sof,
   output logic        frame_done,
   output logic [10:0] frame_len,
   output logic        crc_ok,
   output logic [3:0]  err,
   output logic [15:0] frames_ok,
   output logic [15:0] frames_bad
);

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   // Reset asserts asynchronously but releases two clocks later, synchronous to clk.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_int_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_int_n  = rst_sync_q[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rst_sync_q <= '0;
      else       rst_sync_q <= rst_sync_d;
   end

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  byte_q, byte_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [10:0] len_q, len_d;
   logic [31:0] crc_q, crc_d;
   logic        rxer_q, rxer_d;
   logic        first_q, first_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_sof_q, out_sof_d;
   logic        frame_done_q, frame_done_d;
   logic [10:0] frame_len_q, frame_len_d;
   logic        crc_ok_q, crc_ok_d;
   logic [3:0]  err_q, err_d;
   logic [15:0] frames_ok_q, frames_ok_d;
   logic [15:0] frames_bad_q, frames_bad_d;
   logic [7:0]  new_byte;
   logic        len_err;

   assign new_byte = {rxd, byte_q[7:2]};
   assign len_err  = (int'(len_q) < MIN_LEN) || (int'(len_q) > MAX_LEN);

   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      crc_d        = crc_q;
      rxer_d       = rxer_q;
      first_d      = first_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      out_sof_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_len_d  = frame_len_q;
      crc_ok_d     = crc_ok_q;
      err_d        = err_q;
      frames_ok_d  = frames_ok_q;
      frames_bad_d = frames_bad_q;

      // Counters act on the status registered alongside the frame_done pulse.
      if (frame_done_q) begin
         if (crc_ok_q && (err_q == 4'b0000)) begin
            if (frames_ok_q != 16'hFFFF) frames_ok_d = frames_ok_q + 16'd1;
         end else begin
            if (frames_bad_q != 16'hFFFF) frames_bad_d = frames_bad_q + 16'd1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (rx_dv) state_d = (rxd == 2'b01) ? PREAMBLE : DROP;
         end
         PREAMBLE: begin
            if (!rx_dv) begin
               state_d = IDLE;
            end else if (rxd == 2'b11) begin
               state_d = DATA;
               cnt_d   = 2'd0;
               len_d   = 11'd0;
               crc_d   = 32'hFFFFFFFF;
               rxer_d  = 1'b0;
               first_d = 1'b1;
            end else if (rxd != 2'b01) begin
               state_d = DROP;
            end
         end
         DATA: begin
            if (!rx_dv) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
               frame_len_d  = len_q;
               crc_ok_d     = (crc_q == CRC_RESIDUE);
               err_d        = {len_err, (cnt_q != 2'd0), rxer_q, 1'b0};
            end else begin
               byte_d = new_byte;
               cnt_d  = cnt_q + 2'd1;
               if (rx_er) rxer_d = 1'b1;
               if (cnt_q == 2'd3) begin
                  out_valid_d = 1'b1;
                  out_data_d  = new_byte;
                  out_sof_d   = first_q;
                  first_d     = 1'b0;
                  if (len_q != 11'h7FF) len_d = len_q + 11'd1;
                  crc_d = crc_byte(crc_q, new_byte);
               end
            end
         end
         DROP: begin
            if (!rx_dv) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
               frame_len_d  = 11'd0;
               crc_ok_d     = 1'b0;
               err_d        = 4'b0001;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q      <= IDLE;
         byte_q       <= '0;
         cnt_q        <= '0;
         len_q        <= '0;
         crc_q        <= '1;
         rxer_q       <= 1'b0;
         first_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sof_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_len_q  <= '0;
         crc_ok_q     <= 1'b0;
         err_q        <= '0;
         frames_ok_q  <= '0;
         frames_bad_q <= '0;
      end else begin
         state_q      <= state_d;
         byte_q       <= byte_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         crc_q        <= crc_d;
         rxer_q       <= rxer_d;
         first_q      <= first_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sof_q    <= out_sof_d;
         frame_done_q <= frame_done_d;
         frame_len_q  <= frame_len_d;
         crc_ok_q     <= crc_ok_d;
         err_q        <= err_d;
         frames_ok_q  <= frames_ok_d;
         frames_bad_q <= frames_bad_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_sof    = out_sof_q;
   assign frame_done = frame_done_q;
   assign frame_len  = frame_len_q;
   assign crc_ok     = crc_ok_q;
   assign err        = err_q;
   assign frames_ok  = frames_ok_q;
   assign frames_bad = frames_bad_q;

endmodule

// File: tb/tb_rmii_rx_checker.sv
// Directed bench for rmii_rx_checker: builds RMII frames with a bit-serial
// CRC model and checks byte stream, frame status and counters.
module tb_rmii_rx_checker;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  rxd;
   logic        rx_dv;
   logic        rx_er;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sof;
   logic        frame_done;
   logic [10:0] frame_len;
   logic        crc_ok;
   logic [3:0]  err;
   logic [15:0] frames_ok;
   logic [15:0] frames_bad;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  rx_q[$];
   logic [1:0]  dib_q[$];
   int          sof_cnt = 0;
   logic [7:0]  sof_byte = 8'h00;
   int          done_cnt = 0;

   rmii_rx_checker #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
      .clk(clk), .rstn(rstn), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
      .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
      .frame_done(frame_done), .frame_len(frame_len), .crc_ok(crc_ok), .err(err),
      .frames_ok(frames_ok), .frames_bad(frames_bad)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid) begin
         rx_q.push_back(out_data);
         if (out_sof) begin
            sof_cnt++;
            sof_byte = out_data;
         end
      end
      if (frame_done) done_cnt++;
   end

   function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ b[i];
         r  = {1'b0, r[31:1]};
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   // Preamble + SFD + npay bytes 0,1,2.. + FCS (LSB first), as dibits in dib_q.
   task automatic make_frame(input int npay, input bit flip_fcs);
      logic [7:0]  bytes_q[$];
      logic [31:0] c;
      logic [7:0]  b;
      bytes_q = {};
      for (int i = 0; i < 7; i++) bytes_q.push_back(8'h55);
      bytes_q.push_back(8'hD5);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < npay; i++) begin
         b = i[7:0];
         bytes_q.push_back(b);
         c = model_crc(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) begin
         b = c[8*k +: 8];
         if (flip_fcs && k == 3) b = ~b;
         bytes_q.push_back(b);
      end
      dib_q = {};
      foreach (bytes_q[i]) begin
         b = bytes_q[i];
         for (int j = 0; j < 4; j++) dib_q.push_back(b[2*j +: 2]);
      end
   endtask

   task automatic drive_frame(input int er_pos);
      foreach (dib_q[i]) begin
         @(negedge clk);
         rxd   = dib_q[i];
         rx_dv = 1'b1;
         rx_er = (i == er_pos);
      end
      @(negedge clk);
      rx_dv = 1'b0;
      rx_er = 1'b0;
      rxd   = 2'b00;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 40 && done_cnt < target; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      n_cmp++; if (done_cnt !== target) begin n_err++; $display("FAIL frame_done_count: got %0d want %0d", done_cnt, target); end
   endtask

   task automatic clear_mon();
      rx_q    = {};
      sof_cnt = 0;
   endtask

   task automatic test_reset();
      n_cmp++; if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_sof !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got %b%b%b want 000", out_valid, frame_done, out_sof); end
      n_cmp++; if (out_data !== 8'h00 || frame_len !== 11'd0) begin n_err++; $display("FAIL reset_data_len: got %h/%0d want 00/0", out_data, frame_len); end
      n_cmp++; if (crc_ok !== 1'b0 || err !== 4'b0000) begin n_err++; $display("FAIL reset_status: got %b/%b want 0/0000", crc_ok, err); end
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (frames_ok !== 16'd0 || frames_bad !== 16'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", frames_ok, frames_bad); end
   endtask

   task automatic test_good();
      int d0;
      d0 = done_cnt;
      clear_mon();
      make_frame(60, 1'b0);
      drive_frame(-1);
      wait_done(d0 + 1);
      n_cmp++; if (rx_q.size() !== 64) begin n_err++; $display("FAIL good_byte_count: got %0d want 64", rx_q.size()); end
      n_cmp++; if (sof_cnt !== 1 || sof_byte !== 8'h00) begin n_err++; $display("FAIL good_sof: got %0d x %h want 1 x 00", sof_cnt, sof_byte); end
      if (rx_q.size() >= 60) begin
         n_cmp++; if (rx_q[0] !== 8'h00 || rx_q[59] !== 8'h3B) begin n_err++; $display("FAIL good_bytes: got %h..%h want 00..3b", rx_q[0], rx_q[59]); end
      end
      n_cmp++; if (frame_len !== 11'd64) begin n_err++; $display("FAIL good_len: got %0d want 64", frame_len); end
      n_cmp++; if (crc_ok !== 1'b1 || err !== 4'b0000) begin n_err++; $display("FAIL good_status: got %b/%b want 1/0000", crc_ok, err); end
      n_cmp++; if (frames_ok !== 16'd1 || frames_bad !== 16'd0) begin n_err++; $display("FAIL good_counters: got %0d/%0d want 1/0", frames_ok, frames_bad); end
   endtask

   task automatic test_bad_fcs();
      int d0;
      d0 = done_cnt;
      make_frame(60, 1'b1);
      drive_frame(-1);
      wait_done(d0 + 1);
      n_cmp++; if (crc_ok !== 1'b0 || err !== 4'b0000) begin n_err++; $display("FAIL badfcs_status: got %b/%b want 0/0000", crc_ok, err); end
      n_cmp++; if (frames_ok !== 16'd1 || frames_bad !== 16'd1) begin n_err++; $display("FAIL badfcs_counters: got %0d/%0d want 1/1", frames_ok, frames_bad); end
   endtask

   task automatic test_rx_er();
      int d0;
      d0 = done_cnt;
      clear_mon();
      make_frame(60, 1'b0);
      drive_frame((8 + 30) * 4 + 1);
      wait_done(d0 + 1);
      n_cmp++; if (err !== 4'b0010) begin n_err++; $display("FAIL rxer_err: got %b want 0010", err); end
      n_cmp++; if (rx_q.size() !== 64) begin n_err++; $display("FAIL rxer_bytes: got %0d want 64", rx_q.size()); end
      n_cmp++; if (frames_bad !== 16'd2) begin n_err++; $display("FAIL rxer_bad: got %0d want 2", frames_bad); end
   endtask

   task automatic test_align();
      int d0;
      d0 = done_cnt;
      clear_mon();
      make_frame(60, 1'b0);
      dib_q.push_back(2'b01);
      dib_q.push_back(2'b10);
      drive_frame(-1);
      wait_done(d0 + 1);
      n_cmp++; if (err !== 4'b0100) begin n_err++; $display("FAIL align_err: got %b want 0100", err); end
      n_cmp++; if (frame_len !== 11'd64 || rx_q.size() !== 64) begin n_err++; $display("FAIL align_len: got %0d/%0d want 64/64", frame_len, rx_q.size()); end
      n_cmp++; if (frames_bad !== 16'd3) begin n_err++; $display("FAIL align_bad: got %0d want 3", frames_bad); end
   endtask

   task automatic test_len();
      int d0;
      d0 = done_cnt;
      make_frame(36, 1'b0);
      drive_frame(-1);
      wait_done(d0 + 1);
      n_cmp++; if (frame_len !== 11'd40 || crc_ok !== 1'b1) begin n_err++; $display("FAIL short_len_crc: got %0d/%b want 40/1", frame_len, crc_ok); end
      n_cmp++; if (err !== 4'b1000) begin n_err++; $display("FAIL short_err: got %b want 1000", err); end
      n_cmp++; if (frames_bad !== 16'd4 || frames_ok !== 16'd1) begin n_err++; $display("FAIL short_counters: got %0d/%0d want 1/4", frames_ok, frames_bad); end
   endtask

   task automatic test_drop();
      int d0;
      d0 = done_cnt;
      clear_mon();
      dib_q = {2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
      drive_frame(-1);
      wait_done(d0 + 1);
      n_cmp++; if (err !== 4'b0001 || frame_len !== 11'd0 || crc_ok !== 1'b0) begin n_err++; $display("FAIL drop_status: got %b/%0d/%b want 0001/0/0", err, frame_len, crc_ok); end
      n_cmp++; if (rx_q.size() !== 0) begin n_err++; $display("FAIL drop_bytes: got %0d want 0", rx_q.size()); end
      n_cmp++; if (frames_bad !== 16'd5) begin n_err++; $display("FAIL drop_bad: got %0d want 5", frames_bad); end
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = done_cnt;
      clear_mon();
      make_frame(60, 1'b0);
      drive_frame(-1);
      drive_frame(-1);
      wait_done(d0 + 2);
      n_cmp++; if (rx_q.size() !== 128 || sof_cnt !== 2) begin n_err++; $display("FAIL b2b_bytes: got %0d/%0d want 128/2", rx_q.size(), sof_cnt); end
      n_cmp++; if (frames_ok !== 16'd3 || frames_bad !== 16'd5) begin n_err++; $display("FAIL b2b_counters: got %0d/%0d want 3/5", frames_ok, frames_bad); end
   endtask

   task automatic test_reset_mid();
      int d0;
      int rpos;
      d0   = done_cnt;
      rpos = (8 + 20) * 4;
      make_frame(60, 1'b0);
      foreach (dib_q[i]) begin
         @(negedge clk);
         rxd   = dib_q[i];
         rx_dv = 1'b1;
         rx_er = 1'b0;
         if (i == rpos) begin
            rstn = 1'b0;
            #1;
            n_cmp++; if (out_valid !== 1'b0 || frame_len !== 11'd0 || err !== 4'b0000 || crc_ok !== 1'b0) begin n_err++; $display("FAIL midreset_status: got %b/%0d/%b/%b want 0/0/0000/0", out_valid, frame_len, err, crc_ok); end
            n_cmp++; if (frames_ok !== 16'd0 || frames_bad !== 16'd0) begin n_err++; $display("FAIL midreset_counters: got %0d/%0d want 0/0", frames_ok, frames_bad); end
         end
         if (i == rpos + 2) rstn = 1'b1;
      end
      @(negedge clk);
      rx_dv = 1'b0;
      rxd   = 2'b00;
      wait_done(d0 + 1);
      n_cmp++; if (err !== 4'b0001 || frames_bad !== 16'd1) begin n_err++; $display("FAIL midreset_tail: got %b/%0d want 0001/1", err, frames_bad); end
      make_frame(60, 1'b0);
      drive_frame(-1);
      wait_done(d0 + 2);
      n_cmp++; if (frames_ok !== 16'd1 || frame_len !== 11'd64) begin n_err++; $display("FAIL midreset_good: got %0d/%0d want 1/64", frames_ok, frame_len); end
   endtask

   initial begin
      rstn  = 1'b0;
      rxd   = 2'b00;
      rx_dv = 1'b0;
      rx_er = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_good();
      test_bad_fcs();
      test_rx_er();
      test_align();
      test_len();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
